fifo_drain: RTL and testbench

Read-side controller for the team's synchronous FIFO (`fifo`: `wr_en`, `rd_en`, `wr_data`, `rd_data`, `full`, `empty`). It issues `rd_en` on the FIFO's read port and absorbs the FIFO's one-cycle registered read latency. Data is presented to a downstream consumer over a valid/ready stream through a 2-entry output buffer. Full throughput is sustained with no word lost or duplicated under backpressure, and delivered words are counted.

---
 rtl/fifo_drain.sv | 153 +++++++++++++++
 tb/tb_fifo_drain.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: read-side controller for the synchronous FIFO.
// It issues rd_en, absorbs the FIFO's one-cycle registered read latency,
// and presents words downstream over valid/ready through a 2-entry buffer.
// Handshakes completed on the stream are counted in word_count.
module fifo_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Buffer: head is the oldest word and drives m_data; tail is the second slot.
    logic [DATA_WIDTH-1:0] buf_head;
    logic [DATA_WIDTH-1:0] buf_tail;
    logic [1:0]            occ;
    logic                  inflight;

    logic                  pop;
    logic                  capture;
    // Words that will be held once this cycle's pop and capture settle.
    // This is also next cycle's occupancy.
    logic [2:0]            occ_after;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_head;
    assign pop     = m_valid & m_ready;
    // A read issued last cycle has its data on rd_data this cycle.
    assign capture = inflight;
    assign busy    = (state != IDLE);

    assign occ_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // A new read is allowed only when it still fits in the buffer after the
    // pending capture and this cycle's pop. Reads are blocked during reset,
    // because a word popped from the FIFO then would be lost.
    assign rd_en = !rst && enable && !empty && (state != DRAIN) && (occ_after < 3'd2);

    // Next-state logic for the run/drain controller.
    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    if ((occ != 2'd0) || inflight) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (occ_after == 3'd0) begin
                    // Buffer empty after this pop and nothing in flight.
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Inflight flag: marks that rd_data carries a word on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
        end
    end

    // Output buffer: append captured words at the tail, shift on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data slots are reset as well because m_data must read 0 after reset.
            buf_head <= '0;
            buf_tail <= '0;
            occ      <= 2'd0;
        end else begin
            occ <= occ_after[1:0];
            case ({capture, pop})
                2'b11: begin
                    // Head advances and the new word goes at the tail.
                    // Occupancy is unchanged.
                    if (occ == 2'd2) begin
                        buf_head <= buf_tail;
                        buf_tail <= rd_data;
                    end else begin
                        buf_head <= rd_data;
                    end
                end
                2'b01: begin
                    buf_head <= buf_tail;
                end
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf_head <= rd_data;
                    end else begin
                        buf_tail <= rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Delivered-word counter; wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
        end else if (pop) begin
            word_count <= word_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: a behavioural FIFO feeds the main instance,
// and a second instance with a 4-bit counter is used for the wrap check.
module tb_fifo_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        rst      = 1'b1;
    logic        enable   = 1'b0;
    logic        m_ready  = 1'b0;
    logic        rd_en;
    logic [7:0]  rd_data  = 8'h00;
    logic        empty;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        busy;
    logic [15:0] word_count;

    // Wrap-test instance signals
    logic        enable_w  = 1'b0;
    logic        m_ready_w = 1'b1;
    logic        rd_en_w;
    logic [7:0]  rd_data_w = 8'h00;
    logic        empty_w   = 1'b0;
    logic [7:0]  m_data_w;
    logic        m_valid_w;
    logic        busy_w;
    logic [3:0]  word_count_w;

    fifo_drain #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .word_count(word_count)
    );

    fifo_drain #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .enable(enable_w), .rd_en(rd_en_w), .rd_data(rd_data_w),
        .empty(empty_w), .m_data(m_data_w), .m_valid(m_valid_w), .m_ready(m_ready_w),
        .busy(busy_w), .word_count(word_count_w)
    );

    // Behavioural FIFO with one-cycle registered read data.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            rd_data <= mem[rd_ptr % 64];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Endless source for the wrap instance: each read returns the next integer.
    always @(posedge clk) begin
        if (rd_en_w === 1'b1) begin
            rd_data_w <= rd_data_w + 8'd1;
        end
    end

    // Read strobe monitor on the main instance.
    int   rd_pulses   = 0;
    logic rd_on_empty = 1'b0;
    always @(negedge clk) begin
        if (rd_en === 1'b1) rd_pulses <= rd_pulses + 1;
        if (rd_en === 1'b1 && empty === 1'b1) rd_on_empty <= 1'b1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr++;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Hard stop in case a bounded loop is ever miscoded.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    int         cyc;
    int         got;
    int         base;
    int         first_rd;
    int         first_pop;
    int         last_pop;
    int         rd_w;
    logic [7:0] exp_d;
    logic       hold_bad;
    logic       order_bad;

    initial begin
        // ---------------- Reset values ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", rd_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_word_count", word_count, 16'h0000);
        tick();
        rst = 1'b0;

        // ---------------- Streaming ----------------
        for (int i = 1; i <= 16; i++) push(8'(i));
        base = rd_pulses;
        enable = 1'b1;
        m_ready = 1'b1;
        cyc = 0; got = 0; first_rd = -1; first_pop = -1; last_pop = -1; exp_d = 8'h01;
        while (got < 16 && cyc < 60) begin
            @(negedge clk);
            if (rd_en === 1'b1 && first_rd < 0) first_rd = cyc;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                check("stream_data", m_data, exp_d);
                exp_d++;
                got++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            tick();
            cyc++;
        end
        check("stream_got", got, 16);
        check("stream_latency", first_pop - first_rd, 2);
        check("stream_back_to_back", last_pop - first_pop, 15);
        @(negedge clk);
        check("stream_word_count", word_count, 16'd16);
        check("stream_rd_en_empty", rd_en, 0);
        check("stream_fifo_empty", empty, 1);
        check("stream_rd_pulses", rd_pulses - base, 16);
        tick();
        enable = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("stream_idle_busy", busy, 0);

        // ---------------- Backpressure ----------------
        tick();
        reset_pulse();
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        base = rd_pulses;
        enable = 1'b1;
        m_ready = 1'b0;
        hold_bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid === 1'b1 && m_data !== 8'hA0) hold_bad = 1'b1;
            tick();
        end
        @(negedge clk);
        check("bp_rd_pulses", rd_pulses - base, 2);
        check("bp_m_valid", m_valid, 1);
        check("bp_m_data_held", m_data, 8'hA0);
        check("bp_hold_stable", hold_bad, 0);
        cyc = 0; got = 0; exp_d = 8'hA0;
        while (got < 8 && cyc < 60) begin
            tick();
            m_ready = (cyc % 2 == 0);
            @(negedge clk);
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                check("bp_data", m_data, exp_d);
                exp_d++;
                got++;
            end
            cyc++;
        end
        check("bp_got", got, 8);
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        check("bp_word_count", word_count, 16'd8);
        check("bp_rd_total", rd_pulses - base, 8);
        tick();
        enable = 1'b0;
        tick();
        tick();

        // ---------------- Enable drop during a read ----------------
        reset_pulse();
        push(8'hB0); push(8'hB1); push(8'hB2);
        base = rd_pulses;
        enable = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        check("drop_rd_c0", rd_en, 1);
        tick();
        @(negedge clk);
        check("drop_rd_c1", rd_en, 1);
        tick();
        enable = 1'b0;
        @(negedge clk);
        check("drop_rd_c2", rd_en, 0);
        check("drop_busy_c2", busy, 1);
        tick();
        @(negedge clk);
        check("drain_busy_c3", busy, 1);
        check("drain_valid_c3", m_valid, 1);
        check("drain_data_c3", m_data, 8'hB0);
        check("drain_rd_c3", rd_en, 0);
        tick();
        @(negedge clk);
        check("drain_busy_c4", busy, 1);
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        check("drain_pop0", m_data, 8'hB0);
        tick();
        @(negedge clk);
        check("drain_pop1", m_data, 8'hB1);
        check("drain_busy_c6", busy, 1);
        tick();
        @(negedge clk);
        check("drain_idle_busy", busy, 0);
        check("drain_idle_valid", m_valid, 0);
        check("drain_rd_total", rd_pulses - base, 2);
        check("drain_word_count", word_count, 16'd2);
        // Re-enable to collect the word left in the FIFO.
        tick();
        enable = 1'b1;
        cyc = 0; got = 0;
        while (got < 1 && cyc < 20) begin
            @(negedge clk);
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                check("resume_data", m_data, 8'hB2);
                got++;
            end
            tick();
            cyc++;
        end
        check("resume_got", got, 1);
        enable = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();

        // ---------------- Reset mid-stream ----------------
        reset_pulse();
        push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
        enable = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        check("mid_rd_c0", rd_en, 1);
        tick();
        @(negedge clk);
        check("mid_rd_c1", rd_en, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rd_in_reset", rd_en, 0);
        tick();
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("mid_valid_after_rst", m_valid, 0);
        check("mid_count_after_rst", word_count, 16'd0);
        check("mid_busy_after_rst", busy, 0);
        tick();
        @(negedge clk);
        check("mid_late_not_captured", m_valid, 0);
        tick();
        enable = 1'b1;
        m_ready = 1'b1;
        cyc = 0; got = 0; exp_d = 8'hC2;
        while (got < 2 && cyc < 20) begin
            @(negedge clk);
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                check("mid_after_data", m_data, exp_d);
                exp_d++;
                got++;
            end
            tick();
            cyc++;
        end
        check("mid_after_got", got, 2);
        enable = 1'b0;
        m_ready = 1'b0;
        tick();
        @(negedge clk);
        check("mid_fifo_empty", empty, 1);

        // ---------------- Counter wrap (CNT_WIDTH = 4) ----------------
        tick();
        enable_w = 1'b1;
        cyc = 0; got = 0; rd_w = 0; exp_d = 8'h01; order_bad = 1'b0;
        while (got < 18 && cyc < 80) begin
            @(negedge clk);
            if (rd_en_w === 1'b1) rd_w++;
            if (m_valid_w === 1'b1 && m_ready_w === 1'b1) begin
                if (m_data_w !== exp_d) order_bad = 1'b1;
                exp_d++;
                got++;
            end
            tick();
            if (rd_w == 18) enable_w = 1'b0;
            cyc++;
        end
        @(negedge clk);
        check("wrap_got", got, 18);
        check("wrap_reads", rd_w, 18);
        check("wrap_order", order_bad, 0);
        check("wrap_word_count", word_count_w, 4'd2);
        check("wrap_valid_end", m_valid_w, 0);
        check("wrap_busy_end", busy_w, 0);

        // ---------------- Global properties ----------------
        check("never_rd_on_empty", rd_on_empty, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
